// File: rtl/rename_map_pkg.sv
// Shared widths and types for the rename stage: architectural/physical
// register tags and the whole-map type.
package rename_map_pkg;

  localparam int PREG_W    = 7;
  localparam int AREG_W    = 5;
  localparam int NUM_AREGS = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;
  typedef preg_t [NUM_AREGS-1:0] map_t;

endpackage

// File: rtl/rename_map_table.sv
// 32-entry architectural-to-physical map with three combinational read
// ports, one write port and a single snapshot/restore checkpoint.
module map_table
  import rename_map_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  areg_t rd_addr1,
  input  areg_t rd_addr2,
  input  areg_t rd_addr3,
  output preg_t rd_data1,
  output preg_t rd_data2,
  output preg_t rd_data3,
  input  logic  wr_en,
  input  areg_t wr_addr,
  input  preg_t wr_data,
  input  logic  snap_en,
  input  logic  restore_en
);

  preg_t map_reg  [NUM_AREGS];
  preg_t ckpt_reg [NUM_AREGS];

  // Reads see the map before this cycle's write, so rs==rd gets the old tag.
  assign rd_data1 = map_reg[rd_addr1];
  assign rd_data2 = map_reg[rd_addr2];
  assign rd_data3 = map_reg[rd_addr3];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AREGS; gi++) begin : g_entry
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) begin
          map_reg[gi]  <= '0;
          ckpt_reg[gi] <= '0;
        end
      end else begin : g_live
        logic wr_hit;
        assign wr_hit = wr_en && (wr_addr == areg_t'(gi));

        always_ff @(posedge clk) begin
          if (!reset) begin
            map_reg[gi] <= preg_t'(gi);
          end else if (restore_en) begin
            map_reg[gi] <= ckpt_reg[gi];
          end else if (wr_hit) begin
            map_reg[gi] <= wr_data;
          end
        end

        // The snapshot already contains the branch's own destination update.
        always_ff @(posedge clk) begin
          if (!reset) begin
            ckpt_reg[gi] <= preg_t'(gi);
          end else if (snap_en) begin
            ckpt_reg[gi] <= wr_hit ? wr_data : map_reg[gi];
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rename_map.sv
// Rename stage: map lookup, free-list pop, one branch checkpoint and a
// single-entry output register with valid/ready handshake.
module rename_map
  import rename_map_pkg::*;
#(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AREG_W-1:0]    in_rs1,
  input  logic [AREG_W-1:0]    in_rs2,
  input  logic [AREG_W-1:0]    in_rd,
  input  logic                 in_rd_wr,
  input  logic                 in_is_branch,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 fl_read_en,
  input  logic [PREG_W-1:0]    fl_pd_new,
  input  logic                 fl_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PREG_W-1:0]    out_ps1,
  output logic [PREG_W-1:0]    out_ps2,
  output logic [PREG_W-1:0]    out_pd,
  output logic [PREG_W-1:0]    out_pd_old,
  output logic                 out_has_pd,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 ckpt_busy,
  input  logic                 branch_resolved,
  input  logic                 mispredict
);

  logic needs_pd;
  logic fire;
  preg_t ps1_rd, ps2_rd, pd_old_rd;

  logic                 out_valid_reg;
  preg_t                out_ps1_reg, out_ps2_reg, out_pd_reg, out_pd_old_reg;
  logic                 out_has_pd_reg;
  logic [PAYLOAD_W-1:0] out_payload_reg;
  logic                 ckpt_busy_reg;

  assign needs_pd = in_rd_wr && (in_rd != '0);

  // in_valid deliberately absent so in_ready never depends on it.
  assign in_ready = reset && !mispredict
                 && (!out_valid_reg || out_ready)
                 && !(needs_pd && fl_empty)
                 && !(in_is_branch && ckpt_busy_reg);

  assign fire       = in_valid && in_ready;
  assign fl_read_en = fire && needs_pd;

  map_table u_map_table (
    .clk        (clk),
    .reset      (reset),
    .rd_addr1   (in_rs1),
    .rd_addr2   (in_rs2),
    .rd_addr3   (in_rd),
    .rd_data1   (ps1_rd),
    .rd_data2   (ps2_rd),
    .rd_data3   (pd_old_rd),
    .wr_en      (fire && needs_pd),
    .wr_addr    (in_rd),
    .wr_data    (fl_pd_new),
    .snap_en    (fire && in_is_branch),
    .restore_en (mispredict)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      ckpt_busy_reg <= 1'b0;
    end else if (mispredict) begin
      ckpt_busy_reg <= 1'b0;
    end else if (fire && in_is_branch) begin
      ckpt_busy_reg <= 1'b1;
    end else if (branch_resolved) begin
      ckpt_busy_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_reg   <= 1'b0;
      out_ps1_reg     <= '0;
      out_ps2_reg     <= '0;
      out_pd_reg      <= '0;
      out_pd_old_reg  <= '0;
      out_has_pd_reg  <= 1'b0;
      out_payload_reg <= '0;
    end else if (mispredict) begin
      out_valid_reg <= 1'b0;
    end else if (fire) begin
      out_valid_reg   <= 1'b1;
      out_ps1_reg     <= ps1_rd;
      out_ps2_reg     <= ps2_rd;
      out_pd_reg      <= needs_pd ? fl_pd_new : '0;
      out_pd_old_reg  <= pd_old_rd;
      out_has_pd_reg  <= needs_pd;
      out_payload_reg <= in_payload;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_ps1     = out_ps1_reg;
  assign out_ps2     = out_ps2_reg;
  assign out_pd      = out_pd_reg;
  assign out_pd_old  = out_pd_old_reg;
  assign out_has_pd  = out_has_pd_reg;
  assign out_payload = out_payload_reg;
  assign ckpt_busy   = ckpt_busy_reg;

endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: reset, dependencies, x0, free-list stall,
// backpressure, checkpoint/restore and branch-slot arbitration.
module tb_rename_map;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic        in_rd_wr = 1'b0, in_is_branch = 1'b0;
  logic [31:0] in_payload = '0;
  logic        fl_read_en;
  logic [6:0]  fl_pd_new = '0;
  logic        fl_empty = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [6:0]  out_ps1, out_ps2, out_pd, out_pd_old;
  logic        out_has_pd;
  logic [31:0] out_payload;
  logic        ckpt_busy;
  logic        branch_resolved = 1'b0;
  logic        mispredict = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rename_map #(.PAYLOAD_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .in_is_branch(in_is_branch), .in_payload(in_payload),
    .fl_read_en(fl_read_en), .fl_pd_new(fl_pd_new), .fl_empty(fl_empty),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd), .out_pd_old(out_pd_old),
    .out_has_pd(out_has_pd), .out_payload(out_payload),
    .ckpt_busy(ckpt_busy), .branch_resolved(branch_resolved), .mispredict(mispredict)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rdwr, input logic br,
                        input logic [6:0] pd);
    in_valid     = v;
    in_rs1       = rs1;
    in_rs2       = rs2;
    in_rd        = rd;
    in_rd_wr     = rdwr;
    in_is_branch = br;
    fl_pd_new    = pd;
    in_payload   = {27'h0, rd} ^ 32'hCAFE_0000;
  endtask

  task automatic test_reset();
    set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 7'd32);
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    cyc();
    cyc();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (ckpt_busy !== 1'b0) begin fails++; $display("FAIL reset_ckpt_busy got %b exp 0", ckpt_busy); end
    tests++; if (out_pd !== 7'd0 || out_payload !== 32'd0) begin fails++; $display("FAIL reset_fields got pd=%0d payload=%h exp 0/0", out_pd, out_payload); end
    reset = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || fl_read_en !== 1'b1) begin fails++; $display("FAIL add_pop got ready=%b pop=%b exp 1/1", in_ready, fl_read_en); end
    cyc();
    in_valid = 1'b0;
    tests++; if (out_ps1 !== 7'd1 || out_ps2 !== 7'd2) begin fails++; $display("FAIL add_srcs got %0d,%0d exp 1,2", out_ps1, out_ps2); end
    tests++; if (out_pd !== 7'd32 || out_pd_old !== 7'd3 || out_has_pd !== 1'b1) begin fails++; $display("FAIL add_dst got pd=%0d old=%0d has=%b exp 32/3/1", out_pd, out_pd_old, out_has_pd); end
    tests++; if (out_valid !== 1'b1 || out_payload !== 32'hCAFE_0003) begin fails++; $display("FAIL add_valid got v=%b payload=%h exp 1/cafe0003", out_valid, out_payload); end
    #1;
    tests++; if (fl_read_en !== 1'b0) begin fails++; $display("FAIL add_pop_once got %b exp 0", fl_read_en); end
  endtask

  task automatic test_dependent();
    set_in(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 7'd40);
    cyc();
    tests++; if (out_ps1 !== 7'd1 || out_pd !== 7'd40 || out_pd_old !== 7'd5) begin fails++; $display("FAIL dep1 got ps1=%0d pd=%0d old=%0d exp 1/40/5", out_ps1, out_pd, out_pd_old); end
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 7'd41);
    cyc();
    tests++; if (out_ps1 !== 7'd40 || out_pd !== 7'd41 || out_pd_old !== 7'd6) begin fails++; $display("FAIL dep2 got ps1=%0d pd=%0d old=%0d exp 40/41/6", out_ps1, out_pd, out_pd_old); end
    set_in(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 7'd42);
    cyc();
    tests++; if (out_ps1 !== 7'd40 || out_pd !== 7'd42 || out_pd_old !== 7'd40) begin fails++; $display("FAIL dep3 got ps1=%0d pd=%0d old=%0d exp 40/42/40", out_ps1, out_pd, out_pd_old); end
  endtask

  task automatic test_x0_and_empty();
    set_in(1'b1, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 7'd45);
    #1;
    tests++; if (in_ready !== 1'b1 || fl_read_en !== 1'b0) begin fails++; $display("FAIL x0_pop got ready=%b pop=%b exp 1/0", in_ready, fl_read_en); end
    cyc();
    tests++; if (out_has_pd !== 1'b0 || out_pd !== 7'd0 || out_pd_old !== 7'd0) begin fails++; $display("FAIL x0_dst got has=%b pd=%0d old=%0d exp 0/0/0", out_has_pd, out_pd, out_pd_old); end
    tests++; if (out_ps1 !== 7'd0 || out_ps2 !== 7'd32 || out_valid !== 1'b1) begin fails++; $display("FAIL x0_srcs got %0d,%0d v=%b exp 0,32,1", out_ps1, out_ps2, out_valid); end
    set_in(1'b1, 5'd5, 5'd0, 5'd9, 1'b1, 1'b0, 7'd43);
    fl_empty = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) begin fails++; $display("FAIL empty_stall got ready=%b pop=%b exp 0/0", in_ready, fl_read_en); end
    cyc();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_drain got %b exp 0", out_valid); end
    fl_empty = 1'b0;
    cyc();
    tests++; if (out_ps1 !== 7'd42 || out_pd !== 7'd43 || out_pd_old !== 7'd9) begin fails++; $display("FAIL after_x0 got ps1=%0d pd=%0d old=%0d exp 42/43/9", out_ps1, out_pd, out_pd_old); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 7'd44);
    #1;
    tests++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) begin fails++; $display("FAIL bp_block got ready=%b pop=%b exp 0/0", in_ready, fl_read_en); end
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++; if (out_valid !== 1'b1 || out_pd !== 7'd43 || out_ps1 !== 7'd42) begin fails++; $display("FAIL bp_hold%0d got v=%b pd=%0d ps1=%0d exp 1/43/42", k, out_valid, out_pd, out_ps1); end
      tests++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) begin fails++; $display("FAIL bp_stall%0d got ready=%b pop=%b exp 0/0", k, in_ready, fl_read_en); end
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b1 || fl_read_en !== 1'b1) begin fails++; $display("FAIL bp_release got ready=%b pop=%b exp 1/1", in_ready, fl_read_en); end
    cyc();
    tests++; if (out_pd !== 7'd44 || out_ps1 !== 7'd43 || out_pd_old !== 7'd10) begin fails++; $display("FAIL bp_next got pd=%0d ps1=%0d old=%0d exp 44/43/10", out_pd, out_ps1, out_pd_old); end
  endtask

  task automatic test_checkpoint();
    set_in(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 7'd50);
    cyc();
    tests++; if (ckpt_busy !== 1'b1 || out_pd !== 7'd50 || out_pd_old !== 7'd7) begin fails++; $display("FAIL br_take got busy=%b pd=%0d old=%0d exp 1/50/7", ckpt_busy, out_pd, out_pd_old); end
    set_in(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 7'd51);
    cyc();
    tests++; if (out_ps1 !== 7'd50 || out_pd !== 7'd51) begin fails++; $display("FAIL br_x7 got ps1=%0d pd=%0d exp 50/51", out_ps1, out_pd); end
    set_in(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 7'd52);
    cyc();
    tests++; if (out_pd_old !== 7'd8 || out_pd !== 7'd52) begin fails++; $display("FAIL br_x8 got old=%0d pd=%0d exp 8/52", out_pd_old, out_pd); end
    set_in(1'b1, 5'd7, 5'd8, 5'd13, 1'b1, 1'b0, 7'd53);
    mispredict = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) begin fails++; $display("FAIL mp_block got ready=%b pop=%b exp 0/0", in_ready, fl_read_en); end
    cyc();
    mispredict = 1'b0;
    tests++; if (out_valid !== 1'b0 || ckpt_busy !== 1'b0) begin fails++; $display("FAIL mp_flush got v=%b busy=%b exp 0/0", out_valid, ckpt_busy); end
    cyc();
    tests++; if (out_ps1 !== 7'd50 || out_ps2 !== 7'd8 || out_pd_old !== 7'd13) begin fails++; $display("FAIL mp_restore got ps1=%0d ps2=%0d old=%0d exp 50/8/13", out_ps1, out_ps2, out_pd_old); end
  endtask

  task automatic test_branch_slot();
    set_in(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 7'd60);
    cyc();
    tests++; if (ckpt_busy !== 1'b1) begin fails++; $display("FAIL slot_a got %b exp 1", ckpt_busy); end
    set_in(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 7'd61);
    branch_resolved = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || fl_read_en !== 1'b0) begin fails++; $display("FAIL slot_block got ready=%b pop=%b exp 0/0", in_ready, fl_read_en); end
    cyc();
    branch_resolved = 1'b0;
    tests++; if (ckpt_busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL slot_free got busy=%b v=%b exp 0/0", ckpt_busy, out_valid); end
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL slot_ready got %b exp 1", in_ready); end
    cyc();
    tests++; if (ckpt_busy !== 1'b1 || out_pd !== 7'd61 || out_pd_old !== 7'd12) begin fails++; $display("FAIL slot_b got busy=%b pd=%0d old=%0d exp 1/61/12", ckpt_busy, out_pd, out_pd_old); end
    set_in(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 7'd62);
    cyc();
    tests++; if (out_pd_old !== 7'd60 || out_pd !== 7'd62) begin fails++; $display("FAIL slot_x11 got old=%0d pd=%0d exp 60/62", out_pd_old, out_pd); end
    set_in(1'b1, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0, 7'd0);
    mispredict = 1'b1;
    branch_resolved = 1'b1;
    cyc();
    mispredict = 1'b0;
    branch_resolved = 1'b0;
    tests++; if (ckpt_busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL mp_res_flush got busy=%b v=%b exp 0/0", ckpt_busy, out_valid); end
    cyc();
    in_valid = 1'b0;
    tests++; if (out_ps1 !== 7'd60 || out_ps2 !== 7'd61 || out_has_pd !== 1'b0) begin fails++; $display("FAIL mp_res_restore got ps1=%0d ps2=%0d has=%b exp 60/61/0", out_ps1, out_ps2, out_has_pd); end
  endtask

  initial begin
    test_reset();
    test_dependent();
    test_x0_and_empty();
    test_backpressure();
    test_checkpoint();
    test_branch_slot();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
